md_sequencer: RTL and testbench

Multi-cycle multiply/divide sequencer with architectural HI/LO registers, sitting beside the ALU in the EX stage. It accepts one operation per issue, computes the product or quotient/remainder, and holds `busy` high for a fixed, parameterised latency that mimics the hardware cost. It commits the result to HI/LO at the end of that latency. The hazard unit stalls any MD-class instruction in D while `busy` or `start` is high.

---
 rtl/md_sequencer_pkg.sv | 34 +++
 rtl/md_sequencer_compute.sv | 61 ++++++
 rtl/md_sequencer.sv | 129 ++++++++++++
 tb/tb_md_sequencer.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/md_sequencer_pkg.sv
// md_sequencer_pkg: shared definitions for the multiply/divide sequencer.
// Holds the 4-bit MD_* opcode constants, the default latencies, the FSM
// state type and small opcode-classification helpers.
// Optional feature macro used by the sequencer: MD_DIV0_GUARD_EN.
package md_sequencer_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned MD_OP_W = 4;

    localparam logic [MD_OP_W-1:0] MD_NONE  = 4'd0;
    localparam logic [MD_OP_W-1:0] MD_MULT  = 4'd1;
    localparam logic [MD_OP_W-1:0] MD_MULTU = 4'd2;
    localparam logic [MD_OP_W-1:0] MD_DIV   = 4'd3;
    localparam logic [MD_OP_W-1:0] MD_DIVU  = 4'd4;
    localparam logic [MD_OP_W-1:0] MD_MTHI  = 4'd5;
    localparam logic [MD_OP_W-1:0] MD_MTLO  = 4'd6;

    localparam int unsigned MD_MULT_CYCLES_DEF = 5;
    localparam int unsigned MD_DIV_CYCLES_DEF  = 10;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } md_state_t;

    function automatic logic is_mul_op(input logic [MD_OP_W-1:0] op);
        return (op == MD_MULT) || (op == MD_MULTU);
    endfunction

    function automatic logic is_div_op(input logic [MD_OP_W-1:0] op);
        return (op == MD_DIV) || (op == MD_DIVU);
    endfunction

endpackage

// File: rtl/md_sequencer_compute.sv
// md_sequencer_compute: combinational multiply/divide datapath.
// Ports:
//   mdOp     in  4  : operation code (MD_*)
//   srcA     in  32 : multiplicand / dividend
//   srcB     in  32 : multiplier / divisor
//   result_c out 64 : {hi, lo} result; 0 for non-arithmetic opcodes
// Divide by zero yields {srcA, 0xFFFF_FFFF}; -2^31 / -1 yields
// {0, 0x8000_0000} as a natural consequence of the magnitude divider.
module md_sequencer_compute
    import md_sequencer_pkg::*;
(
    input  logic [MD_OP_W-1:0]  mdOp,
    input  logic [DATA_W-1:0]   srcA,
    input  logic [DATA_W-1:0]   srcB,
    output logic [2*DATA_W-1:0] result_c
);

    logic [2*DATA_W-1:0] a_ext;
    logic [2*DATA_W-1:0] b_ext;
    logic [DATA_W-1:0]   a_mag;
    logic [DATA_W-1:0]   b_mag;
    logic [DATA_W-1:0]   sq_mag;
    logic [DATA_W-1:0]   sr_mag;
    logic [DATA_W-1:0]   sq;
    logic [DATA_W-1:0]   sr;
    logic [DATA_W-1:0]   uq;
    logic [DATA_W-1:0]   ur;
    logic                b_zero;

    // Signed divide runs on magnitudes, then restores signs: quotient
    // negative when operand signs differ, remainder follows the dividend.
    always_comb begin
        a_ext  = {{DATA_W{srcA[DATA_W-1]}}, srcA};
        b_ext  = {{DATA_W{srcB[DATA_W-1]}}, srcB};
        a_mag  = srcA[DATA_W-1] ? (DATA_W'(0) - srcA) : srcA;
        b_mag  = srcB[DATA_W-1] ? (DATA_W'(0) - srcB) : srcB;
        b_zero = (srcB == DATA_W'(0));
        sq_mag = '0;
        sr_mag = '0;
        uq     = '0;
        ur     = '0;
        if (!b_zero) begin
            sq_mag = a_mag / b_mag;
            sr_mag = a_mag % b_mag;
            uq     = srcA / srcB;
            ur     = srcA % srcB;
        end
        sq = (srcA[DATA_W-1] ^ srcB[DATA_W-1]) ? (DATA_W'(0) - sq_mag) : sq_mag;
        sr = srcA[DATA_W-1] ? (DATA_W'(0) - sr_mag) : sr_mag;

        result_c = '0;
        case (mdOp)
            MD_MULT:  result_c = a_ext * b_ext;
            MD_MULTU: result_c = {DATA_W'(0), srcA} * {DATA_W'(0), srcB};
            MD_DIV:   result_c = b_zero ? {srcA, {DATA_W{1'b1}}} : {sr, sq};
            MD_DIVU:  result_c = b_zero ? {srcA, {DATA_W{1'b1}}} : {ur, uq};
            default:  result_c = '0;
        endcase
    end

endmodule

// File: rtl/md_sequencer.sv
// md_sequencer: multi-cycle multiply/divide sequencer with HI/LO registers.
// A long op computes its result on the issue edge into a shadow register,
// holds busy for MULT_CYCLES / DIV_CYCLES cycles, then commits to HI/LO
// and pulses done. mthi/mtlo write HI/LO directly from IDLE.
// Optional macro MD_DIV0_GUARD_EN: divide by zero leaves HI/LO unchanged
// (timing identical); otherwise it commits HI=srcA, LO=0xFFFF_FFFF.
// Ports:
//   clk   in  1  : clock, rising edge
//   reset in  1  : synchronous active-low reset
//   start in  1  : issue strobe
//   mdOp  in  4  : operation code (MD_*)
//   srcA  in  32 : rs / dividend / mthi-mtlo data
//   srcB  in  32 : rt / divisor
//   busy  out 1  : long operation in flight
//   done  out 1  : one-cycle pulse after a long-op commit
//   hi    out 32 : architectural HI
//   lo    out 32 : architectural LO
module md_sequencer
    import md_sequencer_pkg::*;
#(
    parameter int unsigned MULT_CYCLES = MD_MULT_CYCLES_DEF,
    parameter int unsigned DIV_CYCLES  = MD_DIV_CYCLES_DEF
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [MD_OP_W-1:0]  mdOp,
    input  logic [DATA_W-1:0]   srcA,
    input  logic [DATA_W-1:0]   srcB,
    output logic                busy,
    output logic                done,
    output logic [DATA_W-1:0]   hi,
    output logic [DATA_W-1:0]   lo
);

    localparam int unsigned MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int unsigned CNT_W      = $clog2(MAX_CYCLES + 1);

    md_state_t           state_q,  state_d;
    logic [CNT_W-1:0]    cnt_q,    cnt_d;
    logic [2*DATA_W-1:0] shadow_q, shadow_d;
    logic [DATA_W-1:0]   hi_q,     hi_d;
    logic [DATA_W-1:0]   lo_q,     lo_d;
    logic                busy_q,   busy_d;
    logic                done_q,   done_d;
    logic [2*DATA_W-1:0] result_c;

    md_sequencer_compute u_compute (
        .mdOp     (mdOp),
        .srcA     (srcA),
        .srcB     (srcB),
        .result_c (result_c)
    );

    // Next-state, counter, shadow and HI/LO update.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        shadow_d = shadow_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        done_d   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (is_mul_op(mdOp) || is_div_op(mdOp)) begin
                        shadow_d = result_c;
`ifdef MD_DIV0_GUARD_EN
                        // HI/LO cannot change during RUN, so re-committing
                        // their current value leaves them untouched.
                        if (is_div_op(mdOp) && (srcB == DATA_W'(0))) begin
                            shadow_d = {hi_q, lo_q};
                        end
`endif
                        cnt_d   = is_mul_op(mdOp) ? CNT_W'(MULT_CYCLES - 1)
                                                  : CNT_W'(DIV_CYCLES - 1);
                        state_d = ST_RUN;
                    end else if (mdOp == MD_MTHI) begin
                        hi_d = srcA;
                    end else if (mdOp == MD_MTLO) begin
                        lo_d = srcA;
                    end
                end
            end
            ST_RUN: begin
                // start is ignored here: a new issue is a protocol violation.
                if (cnt_q != CNT_W'(0)) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else begin
                    hi_d    = shadow_q[2*DATA_W-1:DATA_W];
                    lo_d    = shadow_q[DATA_W-1:0];
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        busy_d = (state_d == ST_RUN);
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            shadow_q <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            shadow_q <= shadow_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_md_sequencer.sv
// tb_md_sequencer: scoreboard bench for md_sequencer. Stimulus pushes the
// expected {hi,lo} of every long op into a queue; a monitor pops and
// compares whenever done is seen. Inputs change and outputs are sampled on
// the falling edge.
module tb_md_sequencer;
    import md_sequencer_pkg::*;

    localparam int unsigned MULT_N = 5;
    localparam int unsigned DIV_N  = 10;

    logic        clk   = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [3:0]  mdOp  = MD_NONE;
    logic [31:0] srcA  = '0;
    logic [31:0] srcB  = '0;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int checks = 0;
    int errors = 0;
    logic [63:0] exp_q[$];
    logic [31:0] m_hi = '0;
    logic [31:0] m_lo = '0;

    always #5 clk = ~clk;

    md_sequencer #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .mdOp  (mdOp),
        .srcA  (srcA),
        .srcB  (srcB),
        .busy  (busy),
        .done  (done),
        .hi    (hi),
        .lo    (lo)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: architectural result of an op given the current HI/LO.
    function automatic logic [63:0] ref_md(input logic [3:0] op, input logic [31:0] a,
                                           input logic [31:0] b, input logic [31:0] cur_hi,
                                           input logic [31:0] cur_lo);
        longint p;
        int     q;
        int     r;
        case (op)
            MD_MULT: begin
                p = longint'($signed(a)) * longint'($signed(b));
                return 64'(p);
            end
            MD_MULTU: return 64'(a) * 64'(b);
            MD_DIV, MD_DIVU: begin
                if (b == 32'd0) begin
`ifdef MD_DIV0_GUARD_EN
                    return {cur_hi, cur_lo};
`else
                    return {a, 32'hFFFF_FFFF};
`endif
                end
                if (op == MD_DIVU) return {a % b, a / b};
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
                q = $signed(a) / $signed(b);
                r = $signed(a) % $signed(b);
                return {32'(r), 32'(q)};
            end
            default: return {cur_hi, cur_lo};
        endcase
    endfunction

    // Monitor: every done pulse must match the oldest outstanding long op.
    always @(negedge clk) begin
        logic [63:0] e;
        if (done === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: got hi=%h lo=%h with no op outstanding", hi, lo);
            end else begin
                e = exp_q.pop_front();
                check("commit_hilo", {hi, lo}, e);
            end
        end
    end

    // Drive one issue cycle; entered and left just after a falling edge.
    task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        start = 1'b1;
        mdOp  = op;
        srcA  = a;
        srcB  = b;
        @(negedge clk);
        start = 1'b0;
        mdOp  = MD_NONE;
        srcA  = $urandom;
        srcB  = $urandom;
    endtask

    task automatic run_long(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        int          n;
        int          cnt;
        logic [63:0] e;
        n   = is_mul_op(op) ? int'(MULT_N) : int'(DIV_N);
        cnt = 0;
        e   = ref_md(op, a, b, m_hi, m_lo);
        exp_q.push_back(e);
        {m_hi, m_lo} = e;
        issue(op, a, b);
        while (busy === 1'b1 && cnt < 64) begin
            cnt++;
            @(negedge clk);
        end
        check("busy_cycles", 64'(cnt), 64'(n));
    endtask

    task automatic run_short(input logic [3:0] op, input logic [31:0] a);
        if (op == MD_MTHI) m_hi = a;
        else if (op == MD_MTLO) m_lo = a;
        issue(op, a, $urandom);
        check("short_busy", 64'(busy), 64'(0));
        check("short_hilo", {hi, lo}, {m_hi, m_lo});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int          cnt;
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [63:0] e;

        repeat (3) @(negedge clk);
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_done", 64'(done), 64'(0));
        check("rst_hilo", {hi, lo}, 64'd0);
        reset = 1'b1;
        @(negedge clk);

        run_long(MD_MULT, 32'hFFFF_FFFF, 32'd2);
        check("mult_neg", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFE);
        run_long(MD_MULTU, 32'hFFFF_FFFF, 32'd2);
        check("multu", {hi, lo}, 64'h0000_0001_FFFF_FFFE);
        run_long(MD_DIV, 32'hFFFF_FFF9, 32'd2);
        check("div_neg", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFD);
        run_long(MD_DIVU, 32'd7, 32'd2);
        check("divu", {hi, lo}, 64'h0000_0001_0000_0003);
        run_short(MD_MTHI, 32'h1234_5678);
        check("mthi", 64'(hi), 64'h1234_5678);

        // mtlo issued mid-mult must be dropped
        e = ref_md(MD_MULT, 32'd3, 32'd7, m_hi, m_lo);
        exp_q.push_back(e);
        {m_hi, m_lo} = e;
        cnt = 0;
        issue(MD_MULT, 32'd3, 32'd7);
        while (busy === 1'b1 && cnt < 64) begin
            cnt++;
            if (cnt == 2) issue(MD_MTLO, 32'hAA, 32'd0);
            else @(negedge clk);
        end
        check("viol_busy_cycles", 64'(cnt), 64'(MULT_N));
        check("viol_lo", 64'(lo), 64'd21);

        run_short(MD_MTHI, 32'h11);
        run_short(MD_MTLO, 32'h11);
        run_long(MD_DIV, 32'd5, 32'd0);
`ifdef MD_DIV0_GUARD_EN
        check("div0", {hi, lo}, 64'h0000_0011_0000_0011);
`else
        check("div0", {hi, lo}, 64'h0000_0005_FFFF_FFFF);
`endif
        run_long(MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
        check("div_ovf", {hi, lo}, 64'h0000_0000_8000_0000);
        run_long(MD_DIVU, 32'd9, 32'd0);

        // reset during the third busy cycle of a divide discards it
        issue(MD_DIV, 32'd100, 32'd7);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("midrst_busy", 64'(busy), 64'(0));
        check("midrst_done", 64'(done), 64'(0));
        check("midrst_hilo", {hi, lo}, 64'd0);
        reset = 1'b1;
        m_hi  = '0;
        m_lo  = '0;
        repeat (DIV_N + 4) @(negedge clk);
        check("postrst_busy", 64'(busy), 64'(0));
        check("postrst_hilo", {hi, lo}, 64'd0);

        for (int i = 0; i < 40; i++) begin
            op = 4'($urandom_range(0, 6));
            a  = $urandom;
            b  = $urandom;
            case ($urandom_range(0, 7))
                0: b = 32'd0;
                1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                2: b = 32'($urandom_range(1, 9));
                default: ;
            endcase
            if (is_mul_op(op) || is_div_op(op)) run_long(op, a, b);
            else run_short(op, a);
        end

        repeat (3) @(negedge clk);
        check("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
